controle_contador: RTL and testbench
====================================

# controle_contador

Synchronous run controller for the team's N-bit counter datapath. It accepts a start request with a terminal value, counts from 0 up to that value, and reports completion with a one-cycle done pulse. It supports pause, abort and auto-reload (periodic) operation. It sits between control logic and any consumer of the count, replacing free-running ripple counting with a handshaked, fully synchronous sequence.

## Interface
- N, default 4: width of the count, limit and period-counter paths.

- CK  input  1  clock; all state updates on the rising edge.
- CLR  input  1  reset, synchronous, active-high.
- START  input  1  run request, sampled in IDLE only.
- LIM  input  N  terminal count, latched on an accepted START.
- AUTO  input  1  mode select, latched on an accepted START: 0 = single-shot, 1 = auto-reload.
- PAUSE  input  1  level; freezes counting while in RUN.
- ABORT  input  1  level; terminates the run immediately.
- Q  output  N  current count, registered.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle completion pulse, registered.
- CICLOS  output  N  completed-period count, registered; wraps modulo 2^N.

## Operation
- States: IDLE, RUN, FIM.
- Reset: when CLR=1 at an edge, state becomes IDLE and Q, BUSY, DONE, CICLOS, the latched limit and the latched mode all become 0. CLR overrides every other input in every state.
- Priority at each edge: CLR > ABORT > state logic.
- IDLE:
  - START=1 and ABORT=0: latch LIM and AUTO, set Q=0 and CICLOS=0, go to RUN.
  - Otherwise: hold. Q keeps its last value.
- RUN, in evaluation order:
  - ABORT=1: go to IDLE, Q=0, no DONE pulse, CICLOS holds.
  - PAUSE=1: hold Q and state. DONE=0.
  - Q == latched limit, single-shot: go to FIM, Q holds, DONE=1, CICLOS+1.
  - Q == latched limit, auto-reload: stay in RUN, Q=0, DONE=1, CICLOS+1.
  - Otherwise: Q=Q+1 (N bits).
- FIM: lasts exactly one cycle, then IDLE. Q holds the limit. ABORT in FIM gives IDLE with Q=0.
- BUSY is high only in RUN. DONE is 0 at every edge except the completion edges above.
- START while in RUN or FIM is ignored. It does not queue.
- LIM and AUTO changes after acceptance have no effect until the next accepted START.
- LIM=0 is legal:
  - Single-shot: DONE fires one cycle after acceptance.
  - Auto-reload: DONE every cycle and Q stays 0.
- LIM=2^N−1: Q reaches all-ones without overflowing. The compare happens before the increment.
- CICLOS wraps from 2^N−1 to 0 without any flag.

## Timing
- START sampled at edge k gives Q=0 and BUSY=1 after edge k.
- Without pause, Q=j after edge k+j, for j ≤ LIM.
- Single-shot, no pause:
  - DONE=1 after edge k+LIM+1, for one cycle.
  - BUSY falls at the same edge.
  - IDLE after edge k+LIM+2.
  - Total run time is LIM+2 cycles from acceptance to IDLE.
- Each cycle with PAUSE=1 in RUN delays all later events by exactly one cycle.
- Auto-reload: the period is LIM+1 cycles, with a DONE pulse every period. The first DONE is after edge k+LIM+1. The next START can be accepted at the first edge where the state is IDLE.
- ABORT takes effect at the same edge it is sampled: BUSY=0 and Q=0 after that edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: CLR=1 for 2 cycles, then START=0 → Q=0, BUSY=0, DONE=0, CICLOS=0 held.
- Single-shot, LIM=5, AUTO=0:
  - START pulse at edge k → Q goes 0,1,2,3,4,5 after edges k..k+5.
  - DONE=1 only after edge k+6, with Q=5, BUSY=0 and CICLOS=1.
  - IDLE after edge k+7.
  - LIM=0 variant: DONE after edge k+1.
- Pause:
  - LIM=3, PAUSE=1 for 2 cycles while Q=1 → Q holds 1 for those cycles.
  - DONE arrives 2 cycles later than unpaused, at k+6.
  - START pulses during the run are ignored.
- Abort:
  - LIM=9, ABORT=1 at the edge after Q=4 → Q=0, BUSY=0, DONE never pulses.
  - ABORT and START together in IDLE → stays IDLE.
- Auto-reload, LIM=2, AUTO=1, run 20 cycles:
  - Q sequence 0,1,2,0,1,2,…
  - DONE pulses every 3 cycles.
  - CICLOS increments per pulse and wraps 15→0 when N=4 and the run is long enough.
- Reset mid-run: CLR=1 while Q=3 in RUN → the next edge gives IDLE, all outputs 0, latched limit and mode cleared.

Source files
------------

// File: rtl/controle_contador.sv
// Run controller for an N-bit counter: start/limit handshake, pause, abort,
// single-shot or auto-reload operation. Completion is flagged with a one-cycle DONE pulse.
module controle_contador #(
  parameter int unsigned N = 4
) (
  input  logic         CK,
  input  logic         CLR,
  input  logic         START,
  input  logic [N-1:0] LIM,
  input  logic         AUTO,
  input  logic         PAUSE,
  input  logic         ABORT,
  output logic [N-1:0] Q,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] CICLOS
);

  typedef enum logic [1:0] {StIdle, StRun, StFim} state_e;

  localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q;
  logic [N-1:0] q_q;
  logic [N-1:0] lim_q;
  logic [N-1:0] ciclos_q;
  logic         auto_q;
  logic         busy_q;
  logic         done_q;

  always_ff @(posedge CK) begin
    if (CLR) begin
      state_q  <= StIdle;
      q_q      <= '0;
      lim_q    <= '0;
      ciclos_q <= '0;
      auto_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Abort outside IDLE ends the run at once; in IDLE there is nothing to end.
      if (ABORT && (state_q != StIdle)) begin
        state_q <= StIdle;
        q_q     <= '0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (START && !ABORT) begin
              state_q  <= StRun;
              lim_q    <= LIM;
              auto_q   <= AUTO;
              q_q      <= '0;
              ciclos_q <= '0;
              busy_q   <= 1'b1;
            end
          end
          StRun: begin
            if (!PAUSE) begin
              // Compare before increment so an all-ones limit never overflows.
              if (q_q == lim_q) begin
                done_q   <= 1'b1;
                ciclos_q <= ciclos_q + One;
                if (auto_q) begin
                  q_q <= '0;
                end else begin
                  state_q <= StFim;
                  busy_q  <= 1'b0;
                end
              end else begin
                q_q <= q_q + One;
              end
            end
          end
          StFim: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Q      = q_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign CICLOS = ciclos_q;

endmodule

// File: tb/tb_controle_contador.sv
// Directed bench for controle_contador: reset, single-shot, LIM=0, pause, abort,
// auto-reload with period-count wrap, and reset in the middle of a run.
module tb_controle_contador;

  localparam int unsigned N = 4;

  logic         CK = 1'b0;
  logic         CLR, START, AUTO, PAUSE, ABORT;
  logic [N-1:0] LIM;
  logic [N-1:0] Q, CICLOS;
  logic         BUSY, DONE;

  int n_total = 0;
  int n_pass  = 0;

  controle_contador #(.N(N)) dut (
    .CK    (CK),
    .CLR   (CLR),
    .START (START),
    .LIM   (LIM),
    .AUTO  (AUTO),
    .PAUSE (PAUSE),
    .ABORT (ABORT),
    .Q     (Q),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .CICLOS(CICLOS)
  );

  always #5 CK = ~CK;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int q, input int busy, input int done,
                         input int cic);
    chk({tag, ".Q"}, int'(Q), q);
    chk({tag, ".BUSY"}, int'(BUSY), busy);
    chk({tag, ".DONE"}, int'(DONE), done);
    chk({tag, ".CICLOS"}, int'(CICLOS), cic);
  endtask

  initial begin
    CLR = 1'b1; START = 1'b0; AUTO = 1'b0; PAUSE = 1'b0; ABORT = 1'b0; LIM = '0;

    // Reset then idle.
    step(); step();
    chk_all("reset", 0, 0, 0, 0);
    CLR = 1'b0;
    step(); step();
    chk_all("idle", 0, 0, 0, 0);

    // Single-shot LIM=5; LIM changes after acceptance must not matter.
    START = 1'b1; LIM = 4'd5; AUTO = 1'b0;
    step();
    START = 1'b0; LIM = 4'd9; AUTO = 1'b1;
    chk_all("ss5_k", 0, 1, 0, 0);
    for (int j = 1; j <= 5; j++) begin
      step();
      chk_all($sformatf("ss5_q%0d", j), j, 1, 0, 0);
    end
    step();
    chk_all("ss5_done", 5, 0, 1, 1);
    step();
    chk_all("ss5_fim", 5, 0, 0, 1);
    step();
    chk_all("ss5_idle", 5, 0, 0, 1);

    // Single-shot LIM=0.
    START = 1'b1; LIM = 4'd0; AUTO = 1'b0;
    step();
    START = 1'b0;
    chk_all("ss0_k", 0, 1, 0, 0);
    step();
    chk_all("ss0_done", 0, 0, 1, 1);
    step();
    chk_all("ss0_after", 0, 0, 0, 1);

    // Pause with ignored START pulses, LIM=3.
    START = 1'b1; LIM = 4'd3;
    step();
    START = 1'b0;
    chk_all("pz_k", 0, 1, 0, 0);
    step();
    chk_all("pz_k1", 1, 1, 0, 0);
    PAUSE = 1'b1; START = 1'b1;
    step();
    chk_all("pz_k2", 1, 1, 0, 0);
    step();
    chk_all("pz_k3", 1, 1, 0, 0);
    PAUSE = 1'b0; START = 1'b0;
    step();
    chk_all("pz_k4", 2, 1, 0, 0);
    START = 1'b1;
    step();
    chk_all("pz_k5", 3, 1, 0, 0);
    START = 1'b0;
    step();
    chk_all("pz_done", 3, 0, 1, 1);
    step();
    chk_all("pz_fim", 3, 0, 0, 1);
    step();
    chk_all("pz_idle", 3, 0, 0, 1);

    // Abort in RUN, LIM=9, at Q=4.
    START = 1'b1; LIM = 4'd9;
    step();
    START = 1'b0;
    chk_all("ab_k", 0, 1, 0, 0);
    for (int j = 1; j <= 4; j++) step();
    chk_all("ab_q4", 4, 1, 0, 0);
    ABORT = 1'b1;
    step();
    chk_all("ab_hit", 0, 0, 0, 0);
    // ABORT together with START in IDLE stays idle.
    START = 1'b1;
    step();
    chk_all("ab_start", 0, 0, 0, 0);
    ABORT = 1'b0; START = 1'b0;
    for (int j = 0; j < 12; j++) begin
      step();
      chk($sformatf("ab_nodone%0d", j), int'(DONE), 0);
    end

    // Abort in FIM clears Q.
    START = 1'b1; LIM = 4'd1;
    step();
    START = 1'b0;
    step();
    chk_all("abf_q1", 1, 1, 0, 0);
    step();
    chk_all("abf_done", 1, 0, 1, 1);
    ABORT = 1'b1;
    step();
    chk_all("abf_hit", 0, 0, 0, 1);
    ABORT = 1'b0;

    // Auto-reload LIM=2, long enough for CICLOS to wrap.
    START = 1'b1; LIM = 4'd2; AUTO = 1'b1;
    step();
    START = 1'b0; LIM = 4'd7; AUTO = 1'b0;
    chk_all("ar_k", 0, 1, 0, 0);
    for (int i = 1; i <= 52; i++) begin
      step();
      chk_all($sformatf("ar_%0d", i), i % 3, 1, ((i % 3) == 0) ? 1 : 0, (i / 3) % 16);
    end
    ABORT = 1'b1;
    step();
    chk_all("ar_abort", 0, 0, 0, 1);
    ABORT = 1'b0;

    // Auto-reload LIM=0: DONE every cycle, Q stays 0.
    START = 1'b1; LIM = 4'd0; AUTO = 1'b1;
    step();
    START = 1'b0;
    chk_all("ar0_k", 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_all($sformatf("ar0_%0d", i), 0, 1, 1, i);
    end
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;

    // Reset in the middle of a run.
    START = 1'b1; LIM = 4'd7; AUTO = 1'b1;
    step();
    START = 1'b0;
    for (int j = 1; j <= 3; j++) step();
    chk_all("rm_q3", 3, 1, 0, 0);
    CLR = 1'b1;
    step();
    chk_all("rm_clr", 0, 0, 0, 0);
    CLR = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      chk_all($sformatf("rm_idle%0d", j), 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
